// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and lane constants for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD} size_t;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    // Byte offset -> bit offset for byte lanes and halfword lanes.
    localparam int BYTE_LANE_SHIFT = 3;
    localparam int HALF_LANE_SHIFT = 4;

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - little-endian lane extract/extend for loads and merge for stores
module lsu_lane_align
    import lsu_pkg::*;
(
    input  size_t       size,
    input  logic        sign_ext,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  b_sh;
    logic [4:0]  h_sh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] mask;

    always_comb begin
        b_sh   = 5'(offset) << BYTE_LANE_SHIFT;
        h_sh   = 5'(offset[1]) << HALF_LANE_SHIFT;
        lane_b = 8'(word >> b_sh);
        lane_h = 16'(word >> h_sh);
        mask   = 32'h0;
        merged = wdata;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{sign_ext & lane_b[7]}}, lane_b};
                mask      = 32'h0000_00ff << b_sh;
                merged    = (word & ~mask) | (32'(wdata[7:0]) << b_sh);
            end
            SZ_HALF: begin
                load_data = {{16{sign_ext & lane_h[15]}}, lane_h};
                mask      = 32'h0000_ffff << h_sh;
                merged    = (word & ~mask) | (32'(wdata[15:0]) << h_sh);
            end
            default: load_data = word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store sequencer onto a word memory without byte enables
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 128,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic              mem_we,
    output logic [31:0]       mem_address,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    size_t             size_q, size_d;
    logic              signed_q, signed_d;
    logic              we_q, we_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_fault_q, resp_fault_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_address_q, mem_address_d;
    logic [31:0]       mem_writedata_q, mem_writedata_d;

    size_t             req_sz;
    logic              acc_fault;
    logic [31:0]       load_data;
    logic [31:0]       merged;

    lsu_lane_align u_align (
        .size      (size_q),
        .sign_ext  (signed_q),
        .offset    (off_q),
        .word      (mem_readdata),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_comb begin
        req_sz    = size_t'(req_size);
        acc_fault = (req_sz == SZ_BAD)
                 || (req_sz == SZ_HALF && req_addr[0])
                 || (req_sz == SZ_WORD && req_addr[1:0] != 2'b00)
                 || ((req_addr >> 2) >= DEPTH_W);

        state_d         = state_q;
        cnt_d           = cnt_q;
        size_d          = size_q;
        signed_d        = signed_q;
        we_d            = we_q;
        off_d           = off_q;
        wdata_d         = wdata_q;
        req_ready_d     = req_ready_q;
        resp_valid_d    = 1'b0;
        resp_rdata_d    = 32'h0;
        resp_fault_d    = 1'b0;
        mem_we_d        = 1'b0;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    size_d      = req_sz;
                    signed_d    = req_signed;
                    we_d        = req_we;
                    off_d       = req_addr[1:0];
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    if (acc_fault) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                    end else if (req_we && req_sz == SZ_WORD) begin
                        state_d         = WR;
                        mem_we_d        = 1'b1;
                        mem_address_d   = 32'(req_addr >> 2);
                        mem_writedata_d = req_wdata;
                    end else begin
                        state_d       = RD;
                        cnt_d         = '0;
                        mem_address_d = 32'(req_addr >> 2);
                    end
                end
            end
            RD: begin
                if (cnt_q == LAST_CNT) begin
                    if (we_q) begin
                        state_d         = WR;
                        mem_we_d        = 1'b1;
                        mem_writedata_d = merged;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = load_data;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // Reset clears mem_we on the same edge, so an aborted store never writes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            size_q          <= SZ_BYTE;
            signed_q        <= 1'b0;
            we_q            <= 1'b0;
            off_q           <= 2'b00;
            wdata_q         <= 32'h0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= 32'h0;
            resp_fault_q    <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_address_q   <= 32'h0;
            mem_writedata_q <= 32'h0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            size_q          <= size_d;
            signed_q        <= signed_d;
            we_q            <= we_d;
            off_q           <= off_d;
            wdata_q         <= wdata_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_fault_q    <= resp_fault_d;
            mem_we_q        <= mem_we_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_fault    = resp_fault_q;
    assign mem_we        = mem_we_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - self-checking bench for lsu_mem_ctrl at MEM_LAT=1 and MEM_LAT=3
module tb_lsu_mem_ctrl;

    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid [2];
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_fault [2];
    logic        mem_we [2];
    logic [31:0] mem_address [2];
    logic [31:0] mem_writedata [2];
    logic [31:0] mem_readdata [2];

    logic [31:0] phys [2][DEPTH];
    logic [31:0] last_addr [2];
    int          hold_cnt [2];
    int          we_cnt [2];
    logic [31:0] ref_mem [2][DEPTH];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        lsu_mem_ctrl #(.ADDR_W(32), .DEPTH(DEPTH), .MEM_LAT(g == 0 ? 1 : 3)) dut (
            .clk           (clk),
            .reset_n       (reset_n),
            .req_valid     (req_valid[g]),
            .req_ready     (req_ready[g]),
            .req_we        (req_we),
            .req_size      (req_size),
            .req_signed    (req_signed),
            .req_addr      (req_addr),
            .req_wdata     (req_wdata),
            .resp_valid    (resp_valid[g]),
            .resp_rdata    (resp_rdata[g]),
            .resp_fault    (resp_fault[g]),
            .mem_we        (mem_we[g]),
            .mem_address   (mem_address[g]),
            .mem_writedata (mem_writedata[g]),
            .mem_readdata  (mem_readdata[g])
        );
        // Read data is only trustworthy once the address has been held MEM_LAT cycles.
        assign mem_readdata[g] =
            (((mem_address[g] == last_addr[g]) ? hold_cnt[g] + 1 : 1) >= (g == 0 ? 1 : 3))
            ? phys[g][mem_address[g][6:0]] : 32'hBAD0_BAD0;
    end

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (mem_we[g]) begin
                we_cnt[g] <= we_cnt[g] + 1;
                if (mem_address[g] < DEPTH) phys[g][mem_address[g][6:0]] <= mem_writedata[g];
            end
            hold_cnt[g]  <= (mem_address[g] == last_addr[g]) ? hold_cnt[g] + 1 : 1;
            last_addr[g] <= mem_address[g];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic run_req(input int g, input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] ad, input logic [31:0] wd,
                           output logic [31:0] got_rd, output logic got_f);
        int lat, exp_rk, exp_wk, rk, rn, wk, wn, idx, sh;
        logic f, busy_ready, ready_after;
        logic [31:0] old, lane, exp_rd, neww, mask, waddr, wdat;
        lat = (g == 0) ? 1 : 3;
        f = (sz == 2'd3) || (sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 2'b00)
            || (ad / 4 >= DEPTH);
        idx = int'(ad[8:2]);
        sh = int'(ad[1:0]) * 8;
        old = ref_mem[g][idx];
        lane = old >> sh;
        exp_rd = 32'h0;
        neww = old;
        if (!f && !we) begin
            if (sz == 2'd0) begin
                exp_rd = {24'h0, lane[7:0]};
                if (sg && lane[7]) exp_rd = exp_rd | 32'hFFFF_FF00;
            end else if (sz == 2'd1) begin
                exp_rd = {16'h0, lane[15:0]};
                if (sg && lane[15]) exp_rd = exp_rd | 32'hFFFF_0000;
            end else begin
                exp_rd = old;
            end
        end
        if (!f && we) begin
            mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
            mask = mask << sh;
            neww = (old & ~mask) | ((wd << sh) & mask);
        end
        exp_rk = f ? 1 : !we ? lat + 1 : (sz == 2'd2) ? 2 : lat + 2;
        exp_wk = (f || !we) ? 0 : exp_rk - 1;

        @(negedge clk);
        chk("ready_before_req", 32'(req_ready[g]), 32'd1);
        req_we = we; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
        req_valid[g] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[g] = 1'b0;
        req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        rk = 0; rn = 0; wk = 0; wn = 0; busy_ready = 1'b0; ready_after = 1'b0;
        waddr = 32'h0; wdat = 32'h0; got_rd = 32'hFFFF_FFFF; got_f = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (resp_valid[g]) begin
                if (rn == 0) rk = k;
                rn++;
                got_rd = resp_rdata[g];
                got_f = resp_fault[g];
            end
            if (mem_we[g]) begin
                wn++; wk = k; waddr = mem_address[g]; wdat = mem_writedata[g];
            end
            if (req_ready[g] && k <= exp_rk) busy_ready = 1'b1;
            if (k == exp_rk + 1) ready_after = req_ready[g];
        end
        chk("resp_cycle", 32'(rk), 32'(exp_rk));
        chk("resp_pulses", 32'(rn), 32'd1);
        chk("model_fault", 32'(got_f), 32'(f));
        chk("model_rdata", got_rd, exp_rd);
        chk("write_pulses", 32'(wn), (exp_wk != 0) ? 32'd1 : 32'd0);
        if (exp_wk != 0) begin
            chk("write_cycle", 32'(wk), 32'(exp_wk));
            chk("write_addr", waddr, 32'(idx));
            chk("write_data", wdat, neww);
        end
        chk("ready_low_busy", 32'(busy_ready), 32'd0);
        chk("ready_after_resp", 32'(ready_after), 32'd1);
        if (!f && we) ref_mem[g][idx] = neww;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        fault;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                       input logic [31:0] wd, input logic fault, input logic [31:0] rdata);
        vec_t v;
        v.we = we; v.sz = sz; v.sg = sg; v.addr = addr; v.wd = wd; v.fault = fault; v.rdata = rdata;
        tbl.push_back(v);
    endtask

    task automatic chk_reset_values(input int g, input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready[g]), 32'd1);
        chk({tag, "_resp_valid"}, 32'(resp_valid[g]), 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata[g], 32'd0);
        chk({tag, "_resp_fault"}, 32'(resp_fault[g]), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we[g]), 32'd0);
        chk({tag, "_mem_address"}, mem_address[g], 32'd0);
        chk({tag, "_mem_writedata"}, mem_writedata[g], 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        ft;
        logic [10:0] resp_mask, ready_mask;
        logic [31:0] rd_first, rd_second;
        int          wc0;
        logic [1:0]  sz;
        logic [31:0] ad;
        int          r;

        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int g = 0; g < 2; g++) begin
            we_cnt[g] = 0; hold_cnt[g] = 0; last_addr[g] = 32'h0;
            for (int i = 0; i < DEPTH; i++) ref_mem[g][i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        chk_reset_values(0, "reset_lat1");
        chk_reset_values(1, "reset_lat3");
        reset_n = 1'b1;

        for (int g = 0; g < 2; g++)
            for (int i = 0; i < DEPTH; i++) run_req(g, 1'b1, 2'd2, 1'b0, 32'(i * 4), 32'h0, rd, ft);

        add(1, 2, 0, 32'h10,  32'hDEAD_BEEF, 0, 32'h0);
        add(0, 2, 0, 32'h10,  32'h0,         0, 32'hDEAD_BEEF);
        add(1, 2, 0, 32'h10,  32'h1122_3344, 0, 32'h0);
        add(1, 0, 0, 32'h12,  32'h0000_00AA, 0, 32'h0);
        add(0, 2, 0, 32'h10,  32'h0,         0, 32'h11AA_3344);
        add(1, 2, 0, 32'h20,  32'h8000_FF80, 0, 32'h0);
        add(0, 0, 1, 32'h20,  32'h0,         0, 32'hFFFF_FF80);
        add(0, 0, 0, 32'h20,  32'h0,         0, 32'h0000_0080);
        add(0, 1, 1, 32'h22,  32'h0,         0, 32'hFFFF_8000);
        add(0, 1, 0, 32'h22,  32'h0,         0, 32'h0000_8000);
        add(0, 0, 1, 32'h21,  32'h0,         0, 32'hFFFF_FFFF);
        add(1, 1, 0, 32'h22,  32'hABCD_1234, 0, 32'h0);
        add(0, 2, 0, 32'h20,  32'h0,         0, 32'h1234_FF80);
        add(0, 2, 0, 32'h13,  32'h0,         1, 32'h0);
        add(1, 1, 0, 32'h21,  32'h5555_5555, 1, 32'h0);
        add(0, 3, 0, 32'h00,  32'h0,         1, 32'h0);
        add(0, 2, 0, 32'h200, 32'h0,         1, 32'h0);
        add(1, 2, 0, 32'h200, 32'h1234_5678, 1, 32'h0);
        add(1, 2, 0, 32'h1FC, 32'h0BAD_F00D, 0, 32'h0);
        add(0, 2, 0, 32'h1FC, 32'h0,         0, 32'h0BAD_F00D);
        add(1, 0, 0, 32'h1FF, 32'hFFFF_FF77, 0, 32'h0);
        add(0, 2, 0, 32'h1FC, 32'h0,         0, 32'h77AD_F00D);

        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < tbl.size(); i++) begin
                run_req(g, tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wd, rd, ft);
                chk($sformatf("tbl%0d_lat%0d_rdata", i, g), rd, tbl[i].rdata);
                chk($sformatf("tbl%0d_lat%0d_fault", i, g), 32'(ft), 32'(tbl[i].fault));
            end
        end

        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 60; i++) begin
                r = $urandom_range(0, 9);
                sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
                ad = 32'($urandom_range(0, DEPTH + 3)) * 4;
                if ($urandom_range(0, 1) == 1) ad = ad + 32'($urandom_range(0, 3));
                run_req(g, 1'($urandom), sz, 1'($urandom), ad, $urandom, rd, ft);
            end
        end

        // Back-to-back loads with req_valid held high, MEM_LAT=3.
        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h20; req_wdata = 32'h0;
        req_valid[1] = 1'b1;
        resp_mask = '0; ready_mask = '0; rd_first = 32'h0; rd_second = 32'h0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (resp_valid[1]) begin
                resp_mask[k] = 1'b1;
                if (k == 4) rd_first = resp_rdata[1];
                if (k == 9) rd_second = resp_rdata[1];
            end
            if (req_ready[1]) ready_mask[k] = 1'b1;
            if (k == 6) req_valid[1] = 1'b0;
        end
        chk("b2b_resp_cycles", 32'(resp_mask), 32'h0000_0210);
        chk("b2b_ready_cycles", 32'(ready_mask), 32'h0000_0420);
        chk("b2b_rdata_first", rd_first, ref_mem[1][8]);
        chk("b2b_rdata_second", rd_second, ref_mem[1][8]);

        // Reset lands during the RD phase of a byte store.
        run_req(1, 1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFE_F00D, rd, ft);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h31; req_wdata = 32'h55;
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        wc0 = we_cnt[1];
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk_reset_values(1, "midop_reset");
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("midop_no_write", 32'(we_cnt[1]), 32'(wc0));
        chk("midop_ready_after", 32'(req_ready[1]), 32'd1);
        run_req(1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rd, ft);
        chk("midop_word_intact", rd, 32'hCAFE_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator that sits between the CPU datapath and the word-organised data memory.
- Accepts one byte, halfword or word request at a time over a valid/ready handshake.
- Sequences word-wide reads and writes on the memory port, doing read-modify-write for sub-word stores because the memory has no byte enables.
- Returns aligned, extended load data or a fault with a one-cycle response pulse.

Parameters:
- ADDR_W, 32, CPU byte-address width.
- DEPTH, 128, memory size in 32-bit words; valid byte addresses are 0 .. 4*DEPTH-1.
- MEM_LAT, 1, memory read latency in cycles, >=1; address must be held stable for MEM_LAT cycles before readdata is valid.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_signed  in  1  sign-extend sub-word loads.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; sub-word data in the low bits.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and faults.
- resp_fault  out  1  qualified by resp_valid: misaligned, out of range, or illegal size.
- mem_we  out  1  active-high word write strobe.
- mem_address  out  32  word index (byte address >> 2).
- mem_writedata  out  32  word to write.
- mem_readdata  in  32  word read data.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (reset_n sampled on the rising edge of clk).
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_we=0, mem_address=0, mem_writedata=0, latency counter 0.
- Reset mid-operation aborts the access; no partial write may be issued after the reset edge.
- Handshake: accept at a rising edge with req_valid && req_ready. Request fields are captured in registers at accept, so the CPU may change them afterwards. The response has no backpressure.
- States:
  - IDLE: waits for a request.
  - CHECK is folded into IDLE: faults are decoded at accept.
  - RD: holds mem_address for MEM_LAT cycles, counter counts 0..MEM_LAT-1; captures mem_readdata on the last RD cycle.
  - WR: mem_we=1 for exactly one cycle.
  - RESP: resp_valid=1 for one cycle, then back to IDLE.
- Transitions from IDLE, by request type:
  - Fault: IDLE->RESP.
  - Load: IDLE->RD->RESP.
  - Word store: IDLE->WR->RESP.
  - Byte or half store: IDLE->RD->WR->RESP.
- Latency, with accept at edge T:
  - Fault: resp_valid in cycle T+1.
  - Word store: WR in T+1, resp_valid in T+2.
  - Load: resp_valid in T+MEM_LAT+1.
  - Sub-word store: WR in T+MEM_LAT+1, resp_valid in T+MEM_LAT+2.
- Fault rules:
  - Half with addr[0]=1.
  - Word with addr[1:0]!=0.
  - req_size=3.
  - addr>>2 >= DEPTH.
  - A fault makes no memory access (mem_we stays 0) and returns resp_rdata=0.
- Byte lanes are little-endian: a byte lives at bits addr[1:0]*8+7 : addr[1:0]*8, a halfword at addr[1]*16+15 : addr[1]*16.
- Loads: extract the lane, then zero- or sign-extend to 32 bits per req_signed. req_signed is ignored for word loads.
- Sub-word stores: merge req_wdata[7:0] or [15:0] into the captured word. All other bytes are unchanged, and the merged word is driven in WR.
- mem_we is 0 in every state except WR. mem_address stays valid through RD and WR.
- The boundary address 4*DEPTH-4 (word DEPTH-1) is legal; 4*DEPTH faults.

Decomposition:
- Shared package lsu_pkg holds:
  - typedef enum size_t {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD}.
  - The state enum {IDLE, RD, WR, RESP}.
  - Localparams for the lane shift amounts.
- One combinational sub-module, lsu_lane_align, is natural: extract/extend for loads and merge for stores. It is reused by the FSM module lsu_mem_ctrl.

Test Plan:
1. Word store then load, MEM_LAT=1: store 0xDEADBEEF to addr 0x10, then load word from 0x10. Required: mem_we pulse with mem_address=4; load resp_rdata=0xDEADBEEF in T+2; resp_fault=0.
2. Byte store read-modify-write: memory word 4 = 0x11223344; store byte 0xAA to addr 0x12. Required: RD then WR with mem_writedata=0x11AA3344; exactly one mem_we pulse.
3. Signed and unsigned sub-word loads from word 0x8000FF80 at addr 0x20:
   - Signed byte at 0x20 gives 0xFFFFFF80.
   - Unsigned byte at 0x20 gives 0x00000080.
   - Signed half at 0x22 gives 0xFFFF8000.
4. Faults:
   - Word load at 0x13, half store at 0x21, size=3, and word load at 0x200 with DEPTH=128 each give resp_valid with resp_fault=1 in T+1, rdata=0, and no mem_we.
   - Word load at 0x1FC succeeds.
5. Latency and handshake with MEM_LAT=3: hold req_valid high for back-to-back loads. Required: req_ready low from T+1 until after RESP; resp_valid at T+4; second request accepted only in IDLE.
6. Reset mid-operation: reset_n low during the RD of a byte store. Required: no mem_we, all outputs return to reset values next edge, req_ready=1 after reset_n rises.
